uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, CPU output FIFO depth; power of two, at least 2.
REQ-002 SHALL have parameter ADDR_W, default 3, log2(FIFO_DEPTH).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cpu_req  input  1  CPU output flag; a rising edge is one byte request.
REQ-007 SHALL have port cpu_byte  input  8  CPU output byte, sampled on the cpu_req rising-edge cycle.
REQ-008 SHALL have port cpu_full  output  1  FIFO holds FIFO_DEPTH entries; CPU stalls while high.
REQ-009 SHALL have port cpu_overflow  output  1  sticky: a request arrived while the FIFO was full.
REQ-010 SHALL have port dbg_req  input  1  debug-dump level request, held until acknowledged.
REQ-011 SHALL have port dbg_byte  input  8  debug byte, stable while dbg_req is high.
REQ-012 SHALL have port dbg_ack  output  1  one-cycle pulse: debug byte taken.
REQ-013 SHALL have port tx_dv  output  1  start pulse to uart_tx.
REQ-014 SHALL have port tx_byte  output  8  byte to uart_tx, held until the next grant.
REQ-015 SHALL have port tx_done  input  1  uart_tx completion pulse.
REQ-016 SHALL have port busy  output  1  high when state is not IDLE.
REQ-017 SHALL have port fifo_count  output  ADDR_W+1  current FIFO occupancy.

Function
REQ-018 SHALL register cpu_req every cycle; edge = cpu_req high while the registered copy is low.
REQ-019 SHALL write cpu_byte at the tail on an edge with the FIFO not full; fifo_count updates the next cycle.
REQ-020 SHALL drop the byte on an edge with the FIFO full, set cpu_overflow, and leave the FIFO unchanged.
REQ-021 SHALL wrap head and tail pointers modulo FIFO_DEPTH.
REQ-022 SHALL drive cpu_full = (fifo_count == FIFO_DEPTH) combinationally from the count register.
REQ-023 SHALL, on push and pop in the same cycle, perform both and leave the count unchanged; a pop on empty never occurs.
REQ-024 SHALL use FSM states IDLE and WAIT.
REQ-025 SHALL, in IDLE, grant when the FIFO is non-empty or dbg_req is high: latch tx_byte, pulse tx_dv high next cycle, and enter WAIT.
REQ-026 SHALL, on a CPU grant, pop the FIFO head into tx_byte.
REQ-027 SHALL, on a debug grant, latch dbg_byte into tx_byte and pulse dbg_ack high in the same cycle as tx_dv.
REQ-028 SHALL break ties by round-robin: grant the requester not granted last; register last_grant updates on each grant.
REQ-029 SHALL keep tx_dv high exactly one cycle per grant.
REQ-030 SHALL, in WAIT, return to IDLE the cycle after tx_done=1; tx_done in IDLE is ignored.
REQ-031 SHALL allow at most one byte in flight; the earliest next grant is in the IDLE cycle after return.
REQ-032 SHALL continue accepting FIFO pushes in every state.

Reset
REQ-033 SHALL, while rst=0, force: state IDLE, FIFO empty, pointers 0, fifo_count 0, cpu_full 0, cpu_overflow 0, tx_dv 0, tx_byte 0x00, dbg_ack 0, busy 0, last_grant=DBG (CPU wins first tie), edge register 0.
REQ-034 SHALL, on reset during WAIT, abandon the in-flight byte and discard FIFO contents; no tx_dv pulses after release until a new request.

Verification
REQ-035 Single CPU byte: cpu_req rises with cpu_byte=0x41 -> one tx_dv pulse, tx_byte=0x41, busy until tx_done, then fifo_count=0.
REQ-036 Burst: 3 edges 0x10,0x20,0x30 during WAIT -> fifo_count=3, then transmitted in order, one tx_dv per tx_done.
REQ-037 Overflow: 9 edges with tx_done held low (depth 8) -> cpu_full=1 after 8, 9th byte dropped, cpu_overflow=1, first 8 bytes sent intact.
REQ-038 Tie: FIFO non-empty (0xAA) and dbg_req high (0x55) in IDLE after reset -> 0xAA first, then 0x55 with dbg_ack pulse; next tie goes to CPU.
REQ-039 Simultaneous push/pop: cpu_req edge in the same cycle as a CPU grant with count=1 -> count stays 1 and the new byte is sent next.
REQ-040 Reset mid-WAIT with 4 queued bytes -> all outputs at reset values; after release with no stimulus, no tx_dv for 100 cycles.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Byte scheduler in front of a uart_tx: CPU bytes are queued in a small FIFO,
// debug bytes bypass it, and the two sources share the transmitter round-robin.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | transmitter free; grant the next CPU or debug byte if one waits
// ST_WAIT | one byte handed to uart_tx; hold until its tx_done pulse
module uart_tx_scheduler #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [7:0]        cpu_byte,
    output logic              cpu_full,
    output logic              cpu_overflow,
    input  logic              dbg_req,
    input  logic [7:0]        dbg_byte,
    output logic              dbg_ack,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_done,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic {GNT_CPU, GNT_DBG} grant_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    logic              req_q;
    logic              cpu_edge;
    logic              push;
    logic              drop;
    logic              pop;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    state_t            state_q;
    grant_t            last_grant_q;
    logic              tx_dv_q;
    logic              dbg_ack_q;
    logic [7:0]        tx_byte_q;

    logic              cpu_avail;
    logic              pick_cpu;
    logic              pick_dbg;

    assign cpu_edge = cpu_req & ~req_q;
    assign cpu_full = (count_q == DEPTH_CNT);
    assign push     = cpu_edge & ~cpu_full;
    assign drop     = cpu_edge & cpu_full;

    // On a tie the source that did not win last time gets the transmitter.
    assign cpu_avail = (count_q != '0);
    assign pick_cpu  = (state_q == ST_IDLE) && cpu_avail &&
                       (!dbg_req || (last_grant_q == GNT_DBG));
    assign pick_dbg  = (state_q == ST_IDLE) && dbg_req &&
                       (!cpu_avail || (last_grant_q == GNT_CPU));
    assign pop       = pick_cpu;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            tail_d = tail_q + PTR_ONE;
        end
        if (pop) begin
            head_d = head_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q      <= cpu_req;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= cpu_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_DBG;
            tx_dv_q      <= 1'b0;
            dbg_ack_q    <= 1'b0;
            tx_byte_q    <= 8'h00;
        end else begin
            tx_dv_q   <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_cpu) begin
                        tx_byte_q    <= mem_q[head_q];
                        tx_dv_q      <= 1'b1;
                        last_grant_q <= GNT_CPU;
                        state_q      <= ST_WAIT;
                    end else if (pick_dbg) begin
                        tx_byte_q    <= dbg_byte;
                        tx_dv_q      <= 1'b1;
                        dbg_ack_q    <= 1'b1;
                        last_grant_q <= GNT_DBG;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_dv        = tx_dv_q;
    assign tx_byte      = tx_byte_q;
    assign dbg_ack      = dbg_ack_q;
    assign busy         = (state_q != ST_IDLE);
    assign fifo_count   = count_q;
    assign cpu_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a negedge monitor logs every tx_dv
// pulse, and a small responder plays the uart_tx side by returning tx_done.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_req = 1'b0;
    logic [7:0] cpu_byte = 8'h00;
    logic       dbg_req = 1'b0;
    logic [7:0] dbg_byte = 8'h00;
    logic       tx_done = 1'b0;
    logic       cpu_full;
    logic       cpu_overflow;
    logic       dbg_ack;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       busy;
    logic [3:0] fifo_count;

    int checks = 0;
    int passed = 0;

    logic [8:0] tx_log [$];
    logic       prev_dv = 1'b0;
    bit         dv_long = 1'b0;

    bit auto_en = 1'b0;
    int done_cnt = 0;
    int done_req = 0;
    int done_served = 0;

    uart_tx_scheduler #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_byte(cpu_byte),
        .cpu_full(cpu_full), .cpu_overflow(cpu_overflow),
        .dbg_req(dbg_req), .dbg_byte(dbg_byte), .dbg_ack(dbg_ack),
        .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_dv) tx_log.push_back({dbg_ack, tx_byte});
        if (tx_dv && prev_dv) dv_long = 1'b1;
        prev_dv = tx_dv;
    end

    // tx_done source: explicit one-shot requests, or automatic 3 cycles after busy.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst) begin
            done_cnt = 0;
        end else if (done_req != done_served) begin
            done_served++;
            tx_done = 1'b1;
        end else if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) tx_done = 1'b1;
        end else if (auto_en && busy) begin
            done_cnt = 3;
        end
    end

    task automatic cpu_push(input logic [7:0] b);
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_byte = b;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic req_done();
        @(posedge clk); #1;
        done_req++;
    endtask

    task automatic wait_dv(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx_dv) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && fifo_count == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        auto_en = 1'b0;
        rst = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", fifo_count); else passed++;
        checks++; if (tx_dv !== 1'b0) $display("FAIL rst_tx_dv got %b exp 0", tx_dv); else passed++;
        checks++; if (tx_byte !== 8'h00) $display("FAIL rst_tx_byte got %h exp 00", tx_byte); else passed++;
        checks++; if (dbg_ack !== 1'b0) $display("FAIL rst_dbg_ack got %b exp 0", dbg_ack); else passed++;
        checks++; if (cpu_full !== 1'b0) $display("FAIL rst_full got %b exp 0", cpu_full); else passed++;
        checks++; if (cpu_overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", cpu_overflow); else passed++;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        tx_log.delete();
        auto_en = 1'b1;
        cpu_push(8'h41);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd1) $display("FAIL single_count1 got %0d exp 1", fifo_count); else passed++;
        checks++; if (tx_dv !== 1'b0) $display("FAIL single_dv_early got %b exp 0", tx_dv); else passed++;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1) $display("FAIL single_dv got %b exp 1", tx_dv); else passed++;
        checks++; if (tx_byte !== 8'h41) $display("FAIL single_byte got %h exp 41", tx_byte); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b exp 1", busy); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL single_count0 got %0d exp 0", fifo_count); else passed++;
        wait_idle(50, ok);
        checks++; if (ok !== 1'b1) $display("FAIL single_idle_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_log.size() != 1) $display("FAIL single_pulses got %0d exp 1", tx_log.size()); else passed++;
        auto_en = 1'b0;
    endtask

    task automatic test_burst();
        bit ok;
        logic [7:0] exp_b [3] = '{8'h10, 8'h20, 8'h30};
        tx_log.delete();
        auto_en = 1'b0;
        cpu_push(8'h99);
        cpu_push(8'h10);
        cpu_push(8'h20);
        cpu_push(8'h30);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd3) $display("FAIL burst_count got %0d exp 3", fifo_count); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL burst_busy got %b exp 1", busy); else passed++;
        checks++; if (tx_log.size() != 1) $display("FAIL burst_inflight got %0d exp 1", tx_log.size()); else passed++;
        for (int i = 0; i < 3; i++) begin
            req_done();
            wait_dv(20, ok);
            checks++; if (ok !== 1'b1) $display("FAIL burst_dv_timeout%0d got %b exp 1", i, ok); else passed++;
            checks++; if (tx_byte !== exp_b[i]) $display("FAIL burst_byte%0d got %h exp %h", i, tx_byte, exp_b[i]); else passed++;
            checks++; if (fifo_count !== 4'(2 - i)) $display("FAIL burst_count%0d got %0d exp %0d", i, fifo_count, 2 - i); else passed++;
        end
        req_done();
        wait_idle(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL burst_idle_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_log.size() != 4) $display("FAIL burst_pulses got %0d exp 4", tx_log.size()); else passed++;
    endtask

    task automatic test_overflow();
        bit ok;
        logic exp_full;
        logic [8:0] exp_e;
        tx_log.delete();
        auto_en = 1'b0;
        cpu_push(8'hEE);
        for (int i = 0; i < 8; i++) begin
            cpu_push(8'h80 + 8'(i));
            @(negedge clk);
            exp_full = (i == 7);
            checks++; if (fifo_count !== 4'(i + 1)) $display("FAIL ovf_count%0d got %0d exp %0d", i, fifo_count, i + 1); else passed++;
            checks++; if (cpu_full !== exp_full) $display("FAIL ovf_full%0d got %b exp %b", i, cpu_full, exp_full); else passed++;
        end
        checks++; if (cpu_overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", cpu_overflow); else passed++;
        cpu_push(8'h88);
        @(negedge clk);
        checks++; if (cpu_overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", cpu_overflow); else passed++;
        checks++; if (fifo_count !== 4'd8) $display("FAIL ovf_count9 got %0d exp 8", fifo_count); else passed++;
        auto_en = 1'b1;
        wait_idle(300, ok);
        auto_en = 1'b0;
        checks++; if (ok !== 1'b1) $display("FAIL ovf_idle_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_log.size() != 9) $display("FAIL ovf_pulses got %0d exp 9", tx_log.size()); else passed++;
        if (tx_log.size() == 9) begin
            checks++; if (tx_log[0] !== 9'h0EE) $display("FAIL ovf_first got %h exp 0ee", tx_log[0]); else passed++;
            for (int i = 0; i < 8; i++) begin
                exp_e = {1'b0, 8'h80 + 8'(i)};
                checks++; if (tx_log[i + 1] !== exp_e) $display("FAIL ovf_order%0d got %h exp %h", i, tx_log[i + 1], exp_e); else passed++;
            end
        end
        checks++; if (cpu_overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", cpu_overflow); else passed++;
        checks++; if (cpu_full !== 1'b0) $display("FAIL ovf_full_after got %b exp 0", cpu_full); else passed++;
    endtask

    task automatic test_tie();
        bit ok;
        auto_en = 1'b0;
        @(negedge clk);
        checks++; if (cpu_overflow !== 1'b0) $display("FAIL tie_ovf_cleared got %b exp 0", cpu_overflow); else passed++;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_byte = 8'hAA;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b1;
        dbg_byte = 8'h55;
        @(negedge clk);
        checks++; if (fifo_count !== 4'd1) $display("FAIL tie_count got %0d exp 1", fifo_count); else passed++;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1) $display("FAIL tie_dv1 got %b exp 1", tx_dv); else passed++;
        checks++; if (tx_byte !== 8'hAA) $display("FAIL tie_first got %h exp aa", tx_byte); else passed++;
        checks++; if (dbg_ack !== 1'b0) $display("FAIL tie_ack1 got %b exp 0", dbg_ack); else passed++;
        req_done();
        wait_dv(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL tie_dv2_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_byte !== 8'h55) $display("FAIL tie_second got %h exp 55", tx_byte); else passed++;
        checks++; if (dbg_ack !== 1'b1) $display("FAIL tie_ack2 got %b exp 1", dbg_ack); else passed++;
        @(posedge clk); #1 dbg_byte = 8'h66;
        cpu_push(8'hBB);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd1) $display("FAIL tie_count2 got %0d exp 1", fifo_count); else passed++;
        req_done();
        wait_dv(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL tie_dv3_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_byte !== 8'hBB) $display("FAIL tie_rr_cpu got %h exp bb", tx_byte); else passed++;
        checks++; if (dbg_ack !== 1'b0) $display("FAIL tie_ack3 got %b exp 0", dbg_ack); else passed++;
        req_done();
        wait_dv(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL tie_dv4_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_byte !== 8'h66) $display("FAIL tie_dbg2 got %h exp 66", tx_byte); else passed++;
        checks++; if (dbg_ack !== 1'b1) $display("FAIL tie_ack4 got %b exp 1", dbg_ack); else passed++;
        @(posedge clk); #1 dbg_req = 1'b0;
        req_done();
        wait_idle(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL tie_idle_timeout got %b exp 1", ok); else passed++;
    endtask

    task automatic test_push_pop();
        bit ok;
        auto_en = 1'b0;
        cpu_push(8'hC0);
        cpu_push(8'hC1);
        @(negedge clk);
        checks++; if (fifo_count !== 4'd1) $display("FAIL pp_count_pre got %0d exp 1", fifo_count); else passed++;
        @(posedge clk); #1 done_req++;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_byte = 8'hC2;
        @(posedge clk); #1 cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (tx_dv !== 1'b1) $display("FAIL pp_dv got %b exp 1", tx_dv); else passed++;
        checks++; if (tx_byte !== 8'hC1) $display("FAIL pp_byte got %h exp c1", tx_byte); else passed++;
        checks++; if (fifo_count !== 4'd1) $display("FAIL pp_count got %0d exp 1", fifo_count); else passed++;
        req_done();
        wait_dv(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL pp_dv2_timeout got %b exp 1", ok); else passed++;
        checks++; if (tx_byte !== 8'hC2) $display("FAIL pp_next got %h exp c2", tx_byte); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL pp_count_end got %0d exp 0", fifo_count); else passed++;
        req_done();
        wait_idle(20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL pp_idle_timeout got %b exp 1", ok); else passed++;
    endtask

    task automatic test_reset_wait();
        int n0;
        auto_en = 1'b0;
        cpu_push(8'hD0);
        for (int i = 1; i <= 4; i++) cpu_push(8'hD0 + 8'(i));
        @(negedge clk);
        checks++; if (fifo_count !== 4'd4) $display("FAIL rw_count got %0d exp 4", fifo_count); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL rw_busy got %b exp 1", busy); else passed++;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rw_rst_busy got %b exp 0", busy); else passed++;
        checks++; if (fifo_count !== 4'd0) $display("FAIL rw_rst_count got %0d exp 0", fifo_count); else passed++;
        checks++; if (tx_byte !== 8'h00) $display("FAIL rw_rst_byte got %h exp 00", tx_byte); else passed++;
        checks++; if (tx_dv !== 1'b0) $display("FAIL rw_rst_dv got %b exp 0", tx_dv); else passed++;
        checks++; if (dbg_ack !== 1'b0) $display("FAIL rw_rst_ack got %b exp 0", dbg_ack); else passed++;
        checks++; if (cpu_full !== 1'b0) $display("FAIL rw_rst_full got %b exp 0", cpu_full); else passed++;
        @(posedge clk); #1 rst = 1'b1;
        n0 = tx_log.size();
        repeat (100) @(negedge clk);
        checks++; if (tx_log.size() != n0) $display("FAIL rw_quiet got %0d exp %0d", tx_log.size(), n0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rw_quiet_busy got %b exp 0", busy); else passed++;
    endtask

    task automatic test_pulse_width();
        checks++; if (dv_long !== 1'b0) $display("FAIL dv_width got %b exp 0", dv_long); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        do_reset();
        test_tie();
        test_push_pop();
        test_reset_wait();
        test_pulse_width();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
